// File: rtl/nic_pkg.sv
// -----------------------------------------------------------------------------
// nic_pkg : types and constants shared by the ring NIC and its server nodes.
//
// Contents
//   packet_t         : one ring slot (request and response rings use the same
//                      layout).
//   PT_*             : packet type codes carried in packet_t.typ.
//   TRUE / FALSE     : 1-bit constants.
//   ID_GLOBAL_SERVER : ring id of the global server node (62).
//   ID_BROADCAST     : broadcast destination id (63).
//   pkt_empty()      : a slot is empty when both sid and did are zero.
//   make_pkt()       : builds a server-originated packet (age 0, no selects).
// -----------------------------------------------------------------------------
package nic_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [5:0] ID_GLOBAL_SERVER = 6'd62;
    localparam logic [5:0] ID_BROADCAST     = 6'd63;

    localparam logic [3:0] PT_NULL  = 4'd0;
    localparam logic [3:0] PT_READ  = 4'd1;
    localparam logic [3:0] PT_WRITE = 4'd2;
    localparam logic [3:0] PT_AREAD = 4'd3;
    localparam logic [3:0] PT_ACK   = 4'd4;
    localparam logic [3:0] PT_AACK  = 4'd5;
    localparam logic [3:0] PT_RETRY = 4'd6;

    typedef struct packed {
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [5:0]  age;
        logic        ack;
        logic [3:0]  typ;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } packet_t;

    function automatic logic pkt_empty(input packet_t p);
        return (p.sid | p.did) == 6'd0;
    endfunction

    function automatic packet_t make_pkt(input logic [5:0]  sid,
                                         input logic [5:0]  did,
                                         input logic [3:0]  typ,
                                         input logic        ack,
                                         input logic [31:0] adr,
                                         input logic [31:0] dat);
        packet_t p;
        p     = '0;
        p.sid = sid;
        p.did = did;
        p.typ = typ;
        p.ack = ack;
        p.adr = adr;
        p.dat = dat;
        return p;
    endfunction

endpackage

// File: rtl/rf68000_ring_server_fifo.sv
// -----------------------------------------------------------------------------
// rf68000_ring_server_fifo : packet_t-wide synchronous FIFO holding requests
// captured by the ring server until the bus master can perform them.
//
// Ports
//   clk_i  in  clock
//   rst_ni in  asynchronous active-low reset (pointers and count only; the
//              storage is not reset, its contents are simply forgotten)
//   push   in  write din into the tail (ignored while full)
//   din    in  packet to store
//   pop    in  drop the head entry (ignored while empty)
//   head   out oldest entry, valid while empty is low
//   count  out number of stored entries
//   full   out count == DEPTH
//   empty  out count == 0
//
// Handshake: push acts as valid with ~full as ready, pop acts as ready with
// ~empty as valid; a transfer happens only in a cycle where both are high, and
// a simultaneous push and pop leave the count unchanged.
// -----------------------------------------------------------------------------
module rf68000_ring_server_fifo
    import nic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  packet_t                  din,
    input  logic                     pop,
    output packet_t                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    packet_t        mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    cnt_q;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf68000_ring_server.sv
// -----------------------------------------------------------------------------
// rf68000_ring_server : global-server node on the request/response rings.
//
// Requests (read, atomic read, write) addressed to ID are taken off the
// request ring into a small FIFO and performed one at a time as a bus master.
// Reads answer with ACK/AACK on the response ring; a read that arrives while
// the FIFO is full is answered with RETRY. Writes are never answered.
//
// Ports
//   clk_i / rst_ni      clock, asynchronous active-low reset
//   packet_i/packet_o   request ring in / out (1-cycle registered slot)
//   rpacket_i/rpacket_o response ring in / out (1-cycle registered slot)
//   m_cyc_o .. m_dat_i  system bus master (cyc/stb/ack, we, sel, adr, dat)
//   busy_o              FIFO non-empty or bus cycle in progress
//   full_o              FIFO holds DEPTH entries
//   state_o             master FSM state (0 = IDLE, 1 = BUS)
//
// Optional build macro RF68000_RING_SERVER_TIMEOUT_EN: a bus cycle that sees
// no ack for TIMEOUT cycles is aborted; reads then return 32'hDEADDEAD and
// writes are dropped. Without the macro a bus cycle waits for ack forever.
// -----------------------------------------------------------------------------
module rf68000_ring_server
    import nic_pkg::*;
#(
    parameter logic [5:0] ID      = ID_GLOBAL_SERVER,
    parameter int         DEPTH   = 4,
    parameter int         TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  packet_t     packet_i,
    output packet_t     packet_o,
    input  packet_t     rpacket_i,
    output packet_t     rpacket_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    input  logic        m_ack_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        busy_o,
    output logic        full_o,
    output logic        state_o
);

    localparam int PW = $clog2(DEPTH);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUS  = 1'b1;

    logic           state;

    packet_t        head;
    logic [PW:0]    count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    packet_t        resp_q;
    logic           resp_valid;
    packet_t        retry_q;
    logic           retry_valid;

    logic           in_is_req;
    logic           in_is_read;
    logic           hit;
    logic           retry_load;
    logic           head_write;
    logic           start;
    logic           tmo_hit;
    logic           bus_done;
    logic           slot_free;
    logic [31:0]    rd_data;
    logic           unused_head;

    // ---------------------------------------------------------------- capture
    assign in_is_read = (packet_i.typ == PT_READ) || (packet_i.typ == PT_AREAD);
    assign in_is_req  = in_is_read || (packet_i.typ == PT_WRITE);
    // Broadcasts are never consumed, even if ID were configured to 63.
    assign hit        = (packet_i.did == ID) && (packet_i.did != ID_BROADCAST)
                        && in_is_req;
    assign push       = hit && !fifo_full;
    // A write, or a read when the retry slot is taken, keeps circulating.
    assign retry_load = hit && fifo_full && in_is_read && !retry_valid;

    rf68000_ring_server_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .din    (packet_i),
        .pop    (pop),
        .head   (head),
        .count  (count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // ------------------------------------------------------------ bus master
    assign head_write = (head.typ == PT_WRITE);
    // A read may only start once the previous read's answer has left, so the
    // single response register can never be overwritten.
    assign start      = (state == ST_IDLE) && !fifo_empty && !m_ack_i
                        && (head_write || !resp_valid);
    assign bus_done   = (state == ST_BUS) && (m_ack_i || tmo_hit);
    assign pop        = bus_done;
    assign slot_free  = pkt_empty(rpacket_i);

`ifdef RF68000_RING_SERVER_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt <= '0;
        end else if (start) begin
            tmo_cnt <= '0;
        end else if ((state == ST_BUS) && !m_ack_i) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Abort on the cycle the counter would reach TIMEOUT; an ack in that same
    // cycle still wins and returns real data.
    assign tmo_hit = (state == ST_BUS) && !m_ack_i
                     && ((tmo_cnt + 8'd1) == 8'(TIMEOUT));
    assign rd_data = m_ack_i ? m_dat_i : 32'hDEADDEAD;
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign rd_data        = m_dat_i;
    assign unused_timeout = |8'(TIMEOUT);
`endif

    assign unused_head = ^{head.did, head.age, head.ack};

    // ---------------------------------------------------------------- outputs
    assign busy_o  = (count != '0) || m_cyc_o;
    assign full_o  = fifo_full;
    assign state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            packet_o    <= '0;
            rpacket_o   <= '0;
            resp_q      <= '0;
            resp_valid  <= FALSE;
            retry_q     <= '0;
            retry_valid <= FALSE;
            m_cyc_o     <= 1'b0;
            m_stb_o     <= 1'b0;
            m_we_o      <= 1'b0;
            m_sel_o     <= 4'h0;
            m_adr_o     <= 32'h0;
            m_dat_o     <= 32'h0;
        end else begin
            // Request ring: consumed slots are emptied, everything else passes.
            packet_o <= (push || retry_load) ? '0 : packet_i;

            if (retry_load) begin
                retry_q     <= make_pkt(ID, packet_i.sid, PT_RETRY, FALSE,
                                        packet_i.adr, 32'h0);
                retry_valid <= TRUE;
            end

            // Response ring: one insertion per empty slot, response first.
            rpacket_o <= rpacket_i;
            if (slot_free) begin
                if (resp_valid) begin
                    rpacket_o  <= resp_q;
                    resp_valid <= FALSE;
                end else if (retry_valid) begin
                    rpacket_o   <= retry_q;
                    retry_valid <= FALSE;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_BUS;
                        m_cyc_o <= 1'b1;
                        m_stb_o <= 1'b1;
                        m_we_o  <= head.we;
                        m_adr_o <= head.adr;
                        if (head_write) begin
                            m_sel_o <= head.sel;
                            m_dat_o <= head.dat;
                        end else begin
                            m_sel_o <= 4'hF;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_done) begin
                        state   <= ST_IDLE;
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        m_we_o  <= 1'b0;
                        m_sel_o <= 4'h0;
                        if (!head_write) begin
                            resp_q     <= make_pkt(ID, head.sid,
                                                   (head.typ == PT_AREAD) ? PT_AACK : PT_ACK,
                                                   TRUE, m_adr_o, rd_data);
                            resp_valid <= TRUE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf68000_ring_server.sv
module tb_rf68000_ring_server;
    import nic_pkg::*;

    // ------------------------------------------------------- clock and reset
    logic        clk_i = 1'b0;
    logic        rst_ni;
    packet_t     packet_i;
    packet_t     packet_o;
    packet_t     rpacket_i;
    packet_t     rpacket_o;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_ack_i;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i;
    logic        busy_o;
    logic        full_o;
    logic        state_o;

    always #5 clk_i = ~clk_i;

    rf68000_ring_server #(.ID(6'd62), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .packet_i  (packet_i),
        .packet_o  (packet_o),
        .rpacket_i (rpacket_i),
        .rpacket_o (rpacket_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_ack_i   (m_ack_i),
        .m_we_o    (m_we_o),
        .m_sel_o   (m_sel_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .busy_o    (busy_o),
        .full_o    (full_o),
        .state_o   (state_o)
    );

    // ------------------------------------------------------------ scoreboard
    int checks = 0;
    int errors = 0;
    logic [$bits(packet_t)-1:0] exp_q[$];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------- driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic packet_t mk(input logic [5:0] sid, input logic [5:0] did,
                                   input logic [3:0] typ, input logic we,
                                   input logic [3:0] sel, input logic [31:0] adr,
                                   input logic [31:0] dat);
        packet_t p;
        p     = '0;
        p.sid = sid;
        p.did = did;
        p.typ = typ;
        p.we  = we;
        p.sel = sel;
        p.adr = adr;
        p.dat = dat;
        return p;
    endfunction

    function automatic packet_t rsp(input logic [5:0] did, input logic [3:0] typ,
                                    input logic ack, input logic [31:0] adr,
                                    input logic [31:0] dat);
        packet_t p;
        p     = mk(6'd62, did, typ, 1'b0, 4'h0, adr, dat);
        p.ack = ack;
        return p;
    endfunction

    task automatic wait_cyc(input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!m_cyc_o && n < 20) begin
            step();
            n++;
        end
        if (!m_cyc_o) begin
            checks++;
            errors++;
            ok = 1'b0;
            $display("FAIL %s: got no bus cycle expected m_cyc_o=1 within 20 cycles", name);
        end
    endtask

    task automatic bus_cycle(input string name, input logic [31:0] rdata,
                             input int lat);
        bit ok;
        wait_cyc(name, ok);
        if (ok) begin
            repeat (lat) step();
            m_ack_i = 1'b1;
            m_dat_i = rdata;
            step();
            m_ack_i = 1'b0;
            m_dat_i = 32'h0;
        end
    endtask

    // ---------------------------------------------------------- vector table
    typedef struct {
        string   name;
        packet_t pkt_in;
        packet_t rpk_in;
        packet_t exp_pkt;
        packet_t exp_rpk;
    } vec_t;

    vec_t    vecs[5];
    packet_t filler;
    packet_t p;
    bit      ok;
    int      n;

    initial begin
        filler = mk(6'd1, 6'd2, PT_ACK, 1'b0, 4'h0, 32'h1000_0000, 32'h0);

        vecs[0] = '{"bcast_write",
                    mk(6'd3, 6'd63, PT_WRITE, 1'b1, 4'hF, 32'hFD00_0000, 32'h1111_2222),
                    '0,
                    mk(6'd3, 6'd63, PT_WRITE, 1'b1, 4'hF, 32'hFD00_0000, 32'h1111_2222),
                    '0};
        vecs[1] = '{"foreign_read",
                    mk(6'd3, 6'd4, PT_READ, 1'b0, 4'h0, 32'hFF00_0040, 32'h0),
                    filler,
                    mk(6'd3, 6'd4, PT_READ, 1'b0, 4'h0, 32'hFF00_0040, 32'h0),
                    filler};
        vecs[2] = '{"ack_to_id",
                    mk(6'd5, 6'd62, PT_ACK, 1'b0, 4'h0, 32'hFF00_0050, 32'h5),
                    mk(6'd9, 6'd62, PT_ACK, 1'b0, 4'h0, 32'hFF00_0060, 32'h77),
                    mk(6'd5, 6'd62, PT_ACK, 1'b0, 4'h0, 32'hFF00_0050, 32'h5),
                    mk(6'd9, 6'd62, PT_ACK, 1'b0, 4'h0, 32'hFF00_0060, 32'h77)};
        vecs[3] = '{"retry_typ_to_id",
                    mk(6'd5, 6'd62, PT_RETRY, 1'b0, 4'h0, 32'hFF00_0070, 32'h0),
                    '0,
                    mk(6'd5, 6'd62, PT_RETRY, 1'b0, 4'h0, 32'hFF00_0070, 32'h0),
                    '0};
        vecs[4] = '{"empty_slot", '0, filler, '0, filler};

        // ---- reset: outputs zero even with traffic on the inputs
        rst_ni    = 1'b0;
        packet_i  = mk(6'd3, 6'd62, PT_READ, 1'b0, 4'h0, 32'hFF00_0010, 32'h0);
        rpacket_i = filler;
        m_ack_i   = 1'b0;
        m_dat_i   = 32'h0;
        step();
        step();
        check("rst_packet_o", packet_o, '0);
        check("rst_rpacket_o", rpacket_o, '0);
        check("rst_bus", {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o}, '0);
        check("rst_flags", {busy_o, full_o, state_o}, '0);
        packet_i  = '0;
        rpacket_i = '0;
        rst_ni    = 1'b1;
        step();

        // ---- pass-through table: nothing here may be consumed
        for (int i = 0; i < 5; i++) begin
            packet_i  = vecs[i].pkt_in;
            rpacket_i = vecs[i].rpk_in;
            step();
            check({vecs[i].name, "_pkt"}, packet_o, vecs[i].exp_pkt);
            check({vecs[i].name, "_rpk"}, rpacket_o, vecs[i].exp_rpk);
        end
        packet_i  = '0;
        rpacket_i = '0;
        step();
        check("table_no_bus", {m_cyc_o, busy_o}, 2'b00);

        // ---- read
        packet_i  = mk(6'd3, 6'd62, PT_READ, 1'b0, 4'h0, 32'hFF00_0010, 32'h0);
        rpacket_i = filler;
        step();
        packet_i = '0;
        check("read_capture", packet_o, '0);
        wait_cyc("read_start", ok);
        check("read_adr", m_adr_o, 32'hFF00_0010);
        check("read_ctl", {m_stb_o, m_we_o, m_sel_o, busy_o}, {1'b1, 1'b0, 4'hF, 1'b1});
        repeat (2) step();
        m_ack_i = 1'b1;
        m_dat_i = 32'h1234_5678;
        step();
        m_ack_i = 1'b0;
        m_dat_i = 32'h0;
        check("read_end", {m_cyc_o, m_stb_o, m_sel_o, busy_o}, '0);
        check("read_hold_rpk", rpacket_o, filler);
        rpacket_i = '0;
        step();
        check("read_resp", rpacket_o, rsp(6'd3, PT_ACK, 1'b1, 32'hFF00_0010, 32'h1234_5678));
        step();
        check("read_resp_once", rpacket_o, '0);

        // ---- write
        packet_i = mk(6'd5, 6'd62, PT_WRITE, 1'b1, 4'h3, 32'hFD00_0004, 32'hAABB_CCDD);
        step();
        packet_i = '0;
        check("write_capture", packet_o, '0);
        wait_cyc("write_start", ok);
        check("write_bus", {m_we_o, m_sel_o, m_adr_o, m_dat_o},
              {1'b1, 4'h3, 32'hFD00_0004, 32'hAABB_CCDD});
        m_ack_i = 1'b1;
        step();
        m_ack_i = 1'b0;
        check("write_end", {m_cyc_o, m_we_o, busy_o}, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("write_no_resp", rpacket_o, '0);
        end

        // ---- overflow: bus stalled, four reads fill the FIFO
        rpacket_i = filler;
        for (int i = 0; i < 4; i++) begin
            packet_i = mk(6'(10 + i), 6'd62, (i == 3) ? PT_AREAD : PT_READ, 1'b0,
                          4'h0, 32'hFF00_0100 + 32'(i * 4), 32'h0);
            step();
            check("ovf_capture", packet_o, '0);
        end
        check("ovf_full", {full_o, busy_o, m_cyc_o}, 3'b111);
        packet_i = mk(6'd7, 6'd62, PT_READ, 1'b0, 4'h0, 32'hFF00_0020, 32'h0);
        step();
        check("ovf_retry_take", packet_o, '0);
        p        = mk(6'd8, 6'd62, PT_WRITE, 1'b1, 4'hF, 32'hFD00_0010, 32'h5566_7788);
        packet_i = p;
        step();
        check("ovf_write_pass", packet_o, p);
        p        = mk(6'd9, 6'd62, PT_READ, 1'b0, 4'h0, 32'hFF00_0024, 32'h0);
        packet_i = p;
        step();
        check("ovf_read_pass_retry_busy", packet_o, p);
        check("ovf_still_full", full_o, 1'b1);
        packet_i  = '0;
        rpacket_i = '0;
        step();
        check("ovf_retry_pkt", rpacket_o, rsp(6'd7, PT_RETRY, 1'b0, 32'hFF00_0020, 32'h0));
        step();
        check("ovf_retry_once", rpacket_o, '0);

        // ---- response back-pressure: next read waits for the slot
        rpacket_i = filler;
        bus_cycle("bp_first", 32'hA0A0_A0A0, 0);
        check("bp_not_full", full_o, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {m_cyc_o, state_o, rpacket_o}, {2'b00, filler});
            step();
        end
        rpacket_i = '0;
        step();
        check("bp_resp", rpacket_o, rsp(6'd10, PT_ACK, 1'b1, 32'hFF00_0100, 32'hA0A0_A0A0));
        wait_cyc("bp_second_start", ok);
        check("bp_second_adr", m_adr_o, 32'hFF00_0104);

        // ---- drain remaining reads through the scoreboard
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back(rsp(6'(10 + i), (i == 3) ? PT_AACK : PT_ACK, 1'b1,
                                32'hFF00_0100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i)));
            bus_cycle("drain", 32'hC0DE_0000 + 32'(i), i);
            step();
            check("drain_resp", rpacket_o, exp_q.pop_front());
        end
        step();
        check("drain_idle", {busy_o, full_o, m_cyc_o}, 3'b000);

        // ---- stalled bus: timeout or indefinite wait
        packet_i = mk(6'd9, 6'd62, PT_READ, 1'b0, 4'h0, 32'hFF00_0030, 32'h0);
        step();
        packet_i = '0;
        wait_cyc("stall_start", ok);
`ifdef RF68000_RING_SERVER_TIMEOUT_EN
        n = 0;
        while (m_cyc_o && n < 50) begin
            step();
            n++;
        end
        check("tmo_cycles", 32'(n), 32'd8);
        step();
        check("tmo_resp", rpacket_o, rsp(6'd9, PT_ACK, 1'b1, 32'hFF00_0030, 32'hDEAD_DEAD));
        packet_i = mk(6'd9, 6'd62, PT_READ, 1'b0, 4'h0, 32'hFF00_0034, 32'h0);
        step();
        packet_i = '0;
        wait_cyc("tmo_second_start", ok);
`else
        repeat (20) step();
        check("stall_hold", {m_cyc_o, m_stb_o, state_o}, 3'b111);
`endif

        // ---- asynchronous reset in the middle of a bus cycle
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_bus", {m_cyc_o, m_stb_o, m_sel_o, busy_o, state_o}, '0);
        #3;
        rst_ni = 1'b1;
        step();
        step();
        check("rst_fifo_lost", {busy_o, full_o, m_cyc_o}, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf68000_ring_server.md
Name: rf68000_ring_server

Overview:
- Global-server node (ring id 62) on the request/response packet rings.
- Every node NIC sends ROM, I/O and shared-memory reads and writes to did 62. This block consumes those packets and queues them in a small FIFO.
- It performs the accesses as a bus master on the system bus and returns ACK/AACK/RETRY packets on the response ring.
- It is the downstream consumer of the NIC's request ring and the upstream producer of its response ring.

Parameters:
- ID, 6'd62, ring node id this server answers to.
- DEPTH, 4, request FIFO entries (power of two, ≥2).
- TIMEOUT, 255, bus-cycle cycles before abort (only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- packet_i  in  packet_t  request ring in.
- packet_o  out  packet_t  request ring out.
- rpacket_i  in  packet_t  response ring in.
- rpacket_o  out  packet_t  response ring out.
- m_cyc_o  out  1  bus cycle.
- m_stb_o  out  1  bus strobe.
- m_ack_i  in  1  bus acknowledge.
- m_we_o  out  1  bus write.
- m_sel_o  out  4  byte selects.
- m_adr_o  out  32  address.
- m_dat_o  out  32  write data.
- m_dat_i  in  32  read data.
- busy_o  out  1  FIFO non-empty or bus cycle active.
- full_o  out  1  FIFO count == DEPTH.

Behaviour:
- Reset (rst_ni low, async):
  - All outputs are 0; packet_o and rpacket_o are all-zero.
  - FIFO count and pointers are 0; response and retry registers are invalid; FSM is IDLE.
- Ring pass-through: packet_o <= packet_i and rpacket_o <= rpacket_i every clock (1-cycle latency) unless overridden below.
- An empty slot is (sid|did)==0.
- Capture, when packet_i.did==ID and typ ∈ {PT_READ, PT_AREAD, PT_WRITE}:
  - Count < DEPTH (registered count): push the packet, packet_o <= 0.
  - Full, typ is a read, retry register free: packet_o <= 0. Load the retry register with sid=ID, did=packet_i.sid, age=0, typ=PT_RETRY, adr=packet_i.adr, dat=0.
  - Full, typ is a write, or a read with the retry register busy: the packet passes through unchanged and circulates.
  - Other typ, or did==63: pass through; the server never consumes broadcasts.
- Push and pop in the same cycle are both honoured and count is unchanged. A push when full is impossible, because pop-freed space is visible only next cycle.
- Master FSM states: IDLE, BUS.
- IDLE → BUS when all hold:
  - the FIFO is non-empty;
  - m_ack_i is low;
  - the head is a write, or the response register is invalid.
- On entering BUS:
  - m_cyc_o = m_stb_o = 1; m_we_o = head.we; m_adr_o = head.adr.
  - Write: m_sel_o = head.sel, m_dat_o = head.dat.
  - Read: m_sel_o = 4'hF.
- BUS → IDLE on m_ack_i:
  - Deassert cyc/stb/we, set sel to 0, pop the FIFO.
  - For a read, load the response register with sid=ID, did=head.sid, age=0, typ=(head.typ==PT_AREAD ? PT_AACK : PT_ACK), ack=1, adr=m_adr_o, dat=m_dat_i.
  - A write produces no response.
- Response injection: when rpacket_i is an empty slot, rpacket_o <= the response register if valid, else the retry register if valid. That register is then invalidated. The response register has priority over retry; one insertion per slot.
- A response packet addressed to ID arriving on rpacket_i passes through and is never consumed.
- Reset mid-cycle: bus signals drop immediately and FIFO contents are lost.
- busy_o = (count≠0) | m_cyc_o; full_o = (count==DEPTH), registered.

Optional Feature:
- Macro RF68000_RING_SERVER_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to BUS and increments each BUS cycle without m_ack_i. When it reaches TIMEOUT the cycle is aborted exactly as on ack, but with read data 32'hDEADDEAD; writes are dropped silently.
- Undefined: no counter; BUS waits indefinitely for m_ack_i.

Decomposition:
- Types come from the shared nic_pkg: packet_t, PT_* type codes, TRUE/FALSE.
- Add ID_GLOBAL_SERVER=6'd62 and ID_BROADCAST=6'd63 to nic_pkg.
- One sub-module: rf68000_ring_server_fifo. It is a packet_t-wide synchronous FIFO with push, pop, head, count, full and empty; it resets asynchronously on rst_ni.

Test Plan:
- Read: inject PT_READ sid=3 did=62 adr=FF000010. Bus returns 12345678 after 3 cycles, then an empty rpacket slot arrives. Require: packet_o slot zeroed the next cycle; m_adr_o=FF000010, sel=F; rpacket_o carries did=3, typ=PT_ACK, dat=12345678, adr=FF000010.
- Write: PT_WRITE sid=5 adr=FD000004 sel=3 dat=AABBCCDD. Require: m_we_o=1, sel=3, dat=AABBCCDD; no response packet emitted.
- Overflow: hold m_ack_i low and inject 4 reads, then a 5th read from sid=7 adr=FF000020. Require: full_o=1; retry packet typ=PT_RETRY, did=7, adr=FF000020 on the next empty rpacket slot. A 6th packet (a write) passes through unchanged.
- Response back-pressure: keep rpacket_i non-empty (sid=1, did=2) for 10 cycles after a read completes. Require: the 2nd queued read is not started until the response is injected into the first empty slot.
- Broadcast and foreign: did=63 PT_WRITE and did=4 PT_READ. Require: both appear unchanged on packet_o one cycle later; no bus cycle occurs.
- Timeout (macro defined, TIMEOUT=8): read with m_ack_i never asserted. Require: m_cyc_o drops after 8 cycles; response dat=DEADDEAD. Also assert rst_ni mid-BUS → m_cyc_o=0 immediately.
